// File: rtl/count_display_scanner_pkg.sv
// Shared constants and helpers for the count display scanner.
package count_display_scanner_pkg;

  typedef logic [6:0] seg7_t;

  // Active-low {g,f,e,d,c,b,a} patterns
  localparam seg7_t SEG_BLANK = 7'h7F;
  localparam seg7_t SEG_0     = 7'h40;
  localparam seg7_t SEG_1     = 7'h79;
  localparam seg7_t SEG_2     = 7'h24;
  localparam seg7_t SEG_3     = 7'h30;
  localparam seg7_t SEG_4     = 7'h19;
  localparam seg7_t SEG_5     = 7'h12;
  localparam seg7_t SEG_6     = 7'h02;
  localparam seg7_t SEG_7     = 7'h78;
  localparam seg7_t SEG_8     = 7'h00;
  localparam seg7_t SEG_9     = 7'h10;
  localparam seg7_t SEG_A     = 7'h08;
  localparam seg7_t SEG_B     = 7'h03;
  localparam seg7_t SEG_C     = 7'h46;
  localparam seg7_t SEG_D     = 7'h21;
  localparam seg7_t SEG_E     = 7'h06;
  localparam seg7_t SEG_F     = 7'h0E;

  localparam int unsigned MIN_DIGITS = 2;
  localparam int unsigned MAX_DIGITS = 8;

  // Bits needed to hold 0..n-1, never less than one
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w = w + 1;
    return w;
  endfunction

  // Legal display width
  function automatic bit num_digits_ok(input int unsigned n);
    return (n >= MIN_DIGITS) && (n <= MAX_DIGITS);
  endfunction

endpackage

// File: rtl/count_display_scanner_hex_to_seg7.sv
// Combinational hex digit to active-low 7-segment decoder.
module hex_to_seg7
  import count_display_scanner_pkg::*;
(
  input  logic [3:0] hex,
  output seg7_t      seg_c
);

  // One pattern per nibble value
  always_comb begin
    seg_c = SEG_BLANK;
    case (hex)
      4'h0: seg_c = SEG_0;
      4'h1: seg_c = SEG_1;
      4'h2: seg_c = SEG_2;
      4'h3: seg_c = SEG_3;
      4'h4: seg_c = SEG_4;
      4'h5: seg_c = SEG_5;
      4'h6: seg_c = SEG_6;
      4'h7: seg_c = SEG_7;
      4'h8: seg_c = SEG_8;
      4'h9: seg_c = SEG_9;
      4'hA: seg_c = SEG_A;
      4'hB: seg_c = SEG_B;
      4'hC: seg_c = SEG_C;
      4'hD: seg_c = SEG_D;
      4'hE: seg_c = SEG_E;
      4'hF: seg_c = SEG_F;
      default: seg_c = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/count_display_scanner.sv
// Captures counter changes into a short history and scans it onto a
// common-anode 7-segment display, newest value in the rightmost digit.
module count_display_scanner
  import count_display_scanner_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned CNT_W       = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CNT_W-1:0]      cnt_in,
  input  logic                  clr,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  new_val,
  output logic                  hist_full
);

  localparam int unsigned PRE_W = clog2_min1(REFRESH_DIV);
  localparam int unsigned IDX_W = clog2_min1(NUM_DIGITS);

  // Elaboration-time parameter checks
  if (!num_digits_ok(NUM_DIGITS)) begin : g_bad_digits
    $error("count_display_scanner: NUM_DIGITS out of range 2..8");
  end
  if (CNT_W != 4) begin : g_bad_cnt_w
    $error("count_display_scanner: CNT_W must be 4");
  end
  if (REFRESH_DIV < 1) begin : g_bad_div
    $error("count_display_scanner: REFRESH_DIV must be >= 1");
  end

  logic [CNT_W-1:0]      q1_q, q1_d;
  logic [CNT_W-1:0]      q2_q, q2_d;
  logic [CNT_W-1:0]      prev_q, prev_d;
  logic [CNT_W-1:0]      digit_q [NUM_DIGITS];
  logic [CNT_W-1:0]      digit_d [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] valid_q, valid_d;
  logic [PRE_W-1:0]      pre_q, pre_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  seg7_t                 seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic                  new_val_q, new_val_d;
  logic                  hist_full_q, hist_full_d;

  logic [CNT_W-1:0]      sel_digit_c;
  seg7_t                 dec_seg_c;

  assign sel_digit_c = digit_q[idx_q];

  hex_to_seg7 u_dec (
    .hex   (sel_digit_c),
    .seg_c (dec_seg_c)
  );

  // Synchroniser, change detect and history shift; clr wins over a push
  always_comb begin
    q1_d      = cnt_in;
    q2_d      = q1_q;
    prev_d    = prev_q;
    valid_d   = valid_q;
    new_val_d = 1'b0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) digit_d[i] = digit_q[i];

    if (clr) begin
      valid_d = '0;
      prev_d  = q2_q;
    end else if (q2_q != prev_q) begin
      prev_d     = q2_q;
      new_val_d  = 1'b1;
      digit_d[0] = q2_q;
      valid_d    = {valid_q[NUM_DIGITS-2:0], 1'b1};
      for (int i = 1; i < int'(NUM_DIGITS); i++) digit_d[i] = digit_q[i-1];
    end

    hist_full_d = &valid_d;
  end

  // Refresh prescaler and scan index
  always_comb begin
    pre_d = pre_q + PRE_W'(1);
    idx_d = idx_q;
    if (pre_q == PRE_W'(REFRESH_DIV - 1)) begin
      pre_d = '0;
      idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Display drive for the currently selected digit
  always_comb begin
    for (int i = 0; i < int'(NUM_DIGITS); i++) an_d[i] = (IDX_W'(i) != idx_q);
    seg_d = valid_q[idx_q] ? dec_seg_c : SEG_BLANK;
    dp_d  = !((idx_q == '0) && valid_q[0]);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q1_q        <= '0;
      q2_q        <= '0;
      prev_q      <= '0;
      for (int i = 0; i < int'(NUM_DIGITS); i++) digit_q[i] <= '0;
      valid_q     <= '0;
      pre_q       <= '0;
      idx_q       <= '0;
      an_q        <= '1;
      seg_q       <= SEG_BLANK;
      dp_q        <= 1'b1;
      new_val_q   <= 1'b0;
      hist_full_q <= 1'b0;
    end else begin
      q1_q        <= q1_d;
      q2_q        <= q2_d;
      prev_q      <= prev_d;
      for (int i = 0; i < int'(NUM_DIGITS); i++) digit_q[i] <= digit_d[i];
      valid_q     <= valid_d;
      pre_q       <= pre_d;
      idx_q       <= idx_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      new_val_q   <= new_val_d;
      hist_full_q <= hist_full_d;
    end
  end

  assign an        = an_q;
  assign seg       = seg_q;
  assign dp        = dp_q;
  assign new_val   = new_val_q;
  assign hist_full = hist_full_q;

endmodule

// File: tb/tb_count_display_scanner.sv
// Directed bench for count_display_scanner with a history-queue reference model.
module tb_count_display_scanner;

  localparam int ND = 4;
  localparam int RD = 4;

  localparam logic [6:0] HEX_TAB [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    cnt_in = 4'h0;
  logic          clr = 1'b0;
  logic [ND-1:0] an;
  logic [6:0]    seg;
  logic          dp;
  logic          new_val;
  logic          hist_full;

  int total = 0;
  int bad   = 0;

  count_display_scanner #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (RD),
    .CNT_W       (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cnt_in    (cnt_in),
    .clr       (clr),
    .an        (an),
    .seg       (seg),
    .dp        (dp),
    .new_val   (new_val),
    .hist_full (hist_full)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: history as a queue, scan position from the edge count
  logic [ND-1:0] exp_an   = '1;
  logic [6:0]    exp_seg  = 7'h7F;
  logic          exp_dp   = 1'b1;
  logic          exp_nv   = 1'b0;
  logic          exp_full = 1'b0;
  int            n_edges  = 0;
  logic [3:0]    s1 = 4'h0, s2 = 4'h0, prev = 4'h0;
  logic [3:0]    hist [$];

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      exp_an = '1; exp_seg = 7'h7F; exp_dp = 1'b1; exp_nv = 1'b0; exp_full = 1'b0;
      n_edges = 0; s1 = 4'h0; s2 = 4'h0; prev = 4'h0;
      hist.delete();
    end else begin
      int idx;
      logic [3:0] cur;
      cur = s2;
      idx = (n_edges / RD) % ND;
      for (int b = 0; b < ND; b++) exp_an[b] = (b != idx);
      exp_seg = (idx < hist.size()) ? HEX_TAB[hist[idx]] : 7'h7F;
      exp_dp  = !(idx == 0 && hist.size() > 0);
      exp_nv  = 1'b0;
      if (clr) begin
        hist.delete();
        prev = cur;
      end else if (cur != prev) begin
        hist.push_front(cur);
        if (hist.size() > ND) void'(hist.pop_back());
        prev = cur;
        exp_nv = 1'b1;
      end
      exp_full = (hist.size() == ND);
      s2 = s1;
      s1 = cnt_in;
      n_edges = n_edges + 1;
    end
  end

  // Every-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    check("an", int'(an), int'(exp_an));
    check("seg", int'(seg), int'(exp_seg));
    check("dp", int'(dp), int'(exp_dp));
    check("new_val", int'(new_val), int'(exp_nv));
    check("hist_full", int'(hist_full), int'(exp_full));
  end

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Wait (bounded) until the given digit is enabled
  task automatic wait_an(input logic [ND-1:0] target);
    int found;
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      @(negedge clk);
      if (an == target) found = 1;
    end
    check("wait_an", found, 1);
  endtask

  initial begin
    rst = 1'b1;
    #1 rst = 1'b0;
    cycles(3);
    check("rst_an", int'(an), 'hF);
    check("rst_seg", int'(seg), 'h7F);
    check("rst_dp", int'(dp), 1);
    check("rst_full", int'(hist_full), 0);

    // Idle scan with count held at 0
    rst = 1'b1;
    @(negedge clk);
    check("first_an", int'(an), 'hE);
    check("first_seg", int'(seg), 'h7F);
    cycles(4);
    check("scan_an1", int'(an), 'hD);
    cycles(15);
    check("idle_nv", int'(new_val), 0);

    // 0 -> 3: pulse three edges later
    cnt_in = 4'h3;
    @(negedge clk); check("lat_k", int'(new_val), 0);
    @(negedge clk); check("lat_k1", int'(new_val), 0);
    @(negedge clk); check("lat_k2", int'(new_val), 1);
    @(negedge clk); check("lat_k3", int'(new_val), 0);
    wait_an(4'hE);
    check("d0_is3", int'(seg), 'h30);
    check("d0_dp", int'(dp), 0);
    check("one_full", int'(hist_full), 0);
    wait_an(4'hD);
    check("d1_blank", int'(seg), 'h7F);

    // Steps 1..5, oldest value falls off
    for (int v = 1; v <= 5; v++) begin
      cnt_in = 4'(v);
      cycles(10);
    end
    check("full", int'(hist_full), 1);
    wait_an(4'hE); check("h0", int'(seg), 'h12);
    wait_an(4'hD); check("h1", int'(seg), 'h19);
    wait_an(4'hB); check("h2", int'(seg), 'h30);
    wait_an(4'h7); check("h3", int'(seg), 'h24);

    // F -> 0 wrap is a change
    cnt_in = 4'hF;
    cycles(10);
    cnt_in = 4'h0;
    cycles(10);
    wait_an(4'hE); check("wrap0", int'(seg), 'h40);
    wait_an(4'hD); check("wrapF", int'(seg), 'h0E);

    // clr collides with q2 changing to 7
    cnt_in = 4'h7;
    @(negedge clk);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_nv", int'(new_val), 0);
    cycles(10);
    check("clr_full", int'(hist_full), 0);
    wait_an(4'hE); check("clr_seg0", int'(seg), 'h7F); check("clr_dp", int'(dp), 1);
    wait_an(4'h7); check("clr_seg3", int'(seg), 'h7F);
    cnt_in = 4'h8;
    cycles(10);
    wait_an(4'hE); check("after_clr", int'(seg), 'h00); check("after_clr_dp", int'(dp), 0);

    // Refill, then asynchronous reset mid-scan
    for (int v = 9; v <= 11; v++) begin
      cnt_in = 4'(v);
      cycles(10);
    end
    check("refull", int'(hist_full), 1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_an", int'(an), 'hF);
    check("arst_seg", int'(seg), 'h7F);
    check("arst_dp", int'(dp), 1);
    check("arst_full", int'(hist_full), 0);
    cnt_in = 4'h0;
    cycles(3);
    rst = 1'b1;
    @(negedge clk);
    check("rel_an", int'(an), 'hE);
    check("rel_seg", int'(seg), 'h7F);
    cycles(8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
